// File: rtl/mtf_neuron_seq_if.sv
// Bus bundle for mtf_neuron_seq: update request and operands in, membrane/spike results out.
interface mtf_neuron_seq_if #(
  parameter int unsigned W      = 16,
  parameter int unsigned NUM_TS = 4,
  parameter int unsigned CNT_W  = 16
);
  logic                    tick;
  logic signed [W-1:0]     i_ext;
  logic signed [W-1:0]     thresh;
  logic [NUM_TS*W-1:0]     alpha;
  logic [NUM_TS*W-1:0]     delta;
  logic                    busy;
  logic                    out_valid;
  logic                    spike;
  logic signed [W-1:0]     voltage;
  logic [NUM_TS*W-1:0]     x_state;
  logic [CNT_W-1:0]        spike_count;
  logic                    tick_dropped;

  modport master (
    output tick, i_ext, thresh, alpha, delta,
    input  busy, out_valid, spike, voltage, x_state, spike_count, tick_dropped
  );

  modport slave (
    input  tick, i_ext, thresh, alpha, delta,
    output busy, out_valid, spike, voltage, x_state, spike_count, tick_dropped
  );
endinterface

// File: rtl/mtf_neuron_seq.sv
// Multi-timescale-feedback neuron. Feedback terms alpha_k*sat(x_k - delta_k) are accumulated
// one per cycle on a single multiplier, then membrane, timescale states and spike are updated.
module mtf_neuron_seq #(
  parameter int unsigned         W            = 16,
  parameter int unsigned         FRAC         = 8,
  parameter int unsigned         NUM_TS       = 4,
  parameter logic [4*NUM_TS-1:0] TAU_SHIFTS   = {4'd6, 4'd4, 4'd2, 4'd1},
  parameter int unsigned         REFRAC_TICKS = 0,
  parameter int unsigned         CNT_W        = 16
) (
  input logic             clk,
  input logic             reset,
  mtf_neuron_seq_if.slave bus
);
  localparam int unsigned       AccW  = W + FRAC + $clog2(NUM_TS) + 2;
  localparam int unsigned       IdxW  = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
  localparam int unsigned       RefW  = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;
  localparam logic [IdxW-1:0]   KLast = IdxW'(NUM_TS - 1);
  localparam logic signed [W:0] SatHi = (W+1)'(2 ** FRAC);
  localparam logic signed [W:0] SatLo = -SatHi;

  typedef enum logic [1:0] {StIdle, StAccum, StUpdate} state_e;

  // Clamp a wide signed value into the W-bit two's complement range.
  function automatic logic signed [W-1:0] sat_w(input logic signed [AccW:0] val);
    logic signed [AccW:0] hi;
    logic signed [AccW:0] lo;
    hi = (AccW+1)'({1'b0, {(W-1){1'b1}}});
    lo = ~hi;
    if (val > hi) begin
      sat_w = {1'b0, {(W-1){1'b1}}};
    end else if (val < lo) begin
      sat_w = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_w = val[W-1:0];
    end
  endfunction

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           k_q, k_d;
  logic signed [AccW-1:0]    acc_q, acc_d;
  logic signed [W-1:0]       i_ext_q, i_ext_d, thresh_q, thresh_d;
  logic [NUM_TS*W-1:0]       alpha_q, alpha_d, delta_q, delta_d;
  logic [NUM_TS-1:0][W-1:0]  x_q, x_d;
  logic signed [W-1:0]       voltage_q, voltage_d, prev_q, prev_d;
  logic [RefW-1:0]           refrac_q, refrac_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      out_valid_q, out_valid_d, spike_q, spike_d;
  logic                      tick_dropped_q, tick_dropped_d;

  logic signed [W-1:0]       x_sel, a_sel, d_sel;
  logic signed [W:0]         diff, s_clamp;
  logic signed [2*W:0]       prod;
  logic signed [AccW-1:0]    term;
  logic signed [AccW:0]      v_wide;
  logic signed [W-1:0]       v_new;
  logic signed [W-1:0]       x_cur;
  logic signed [W:0]         x_diff, x_step;
  logic signed [W+1:0]       x_sum;
  logic [NUM_TS-1:0][W-1:0]  x_new;
  logic                      cand;

  // Datapath: current feedback term, saturated membrane, leaked timescale states, crossing test.
  always_comb begin
    x_sel = '0;
    a_sel = '0;
    d_sel = '0;
    for (int i = 0; i < int'(NUM_TS); i++) begin
      if (int'(k_q) == i) begin
        x_sel = $signed(x_q[i]);
        a_sel = $signed(alpha_q[i*W +: W]);
        d_sel = $signed(delta_q[i*W +: W]);
      end
    end
    diff = {x_sel[W-1], x_sel} - {d_sel[W-1], d_sel};
    if (diff > SatHi) begin
      s_clamp = SatHi;
    end else if (diff < SatLo) begin
      s_clamp = SatLo;
    end else begin
      s_clamp = diff;
    end
    prod = (2*W+1)'(a_sel) * (2*W+1)'(s_clamp);
    term = AccW'(prod >>> FRAC);

    v_wide = (AccW+1)'(i_ext_q) - (AccW+1)'(acc_q);
    v_new  = sat_w(v_wide);

    x_new  = '0;
    x_cur  = '0;
    x_diff = '0;
    x_step = '0;
    x_sum  = '0;
    for (int i = 0; i < int'(NUM_TS); i++) begin
      x_cur    = $signed(x_q[i]);
      x_diff   = {v_new[W-1], v_new} - {x_cur[W-1], x_cur};
      x_step   = x_diff >>> TAU_SHIFTS[4*i +: 4];
      x_sum    = (W+2)'(x_cur) + (W+2)'(x_step);
      x_new[i] = sat_w((AccW+1)'(x_sum));
    end

    cand = (v_new >= thresh_q) && (prev_q < thresh_q);
  end

  // Sequencer: latch operands on tick, accumulate NUM_TS terms, then commit the update.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    acc_d          = acc_q;
    i_ext_d        = i_ext_q;
    thresh_d       = thresh_q;
    alpha_d        = alpha_q;
    delta_d        = delta_q;
    x_d            = x_q;
    voltage_d      = voltage_q;
    prev_d         = prev_q;
    refrac_d       = refrac_q;
    count_d        = count_q;
    out_valid_d    = 1'b0;
    spike_d        = 1'b0;
    tick_dropped_d = bus.tick && (state_q != StIdle);
    case (state_q)
      StIdle: begin
        if (bus.tick) begin
          i_ext_d  = bus.i_ext;
          thresh_d = bus.thresh;
          alpha_d  = bus.alpha;
          delta_d  = bus.delta;
          k_d      = '0;
          acc_d    = '0;
          state_d  = StAccum;
        end
      end
      StAccum: begin
        acc_d = acc_q + term;
        if (k_q == KLast) begin
          state_d = StUpdate;
        end else begin
          k_d = k_q + IdxW'(1);
        end
      end
      StUpdate: begin
        state_d     = StIdle;
        out_valid_d = 1'b1;
        voltage_d   = v_new;
        prev_d      = v_new;
        x_d         = x_new;
        // Suppression looks at the refractory count before this update's decrement.
        if (cand && (refrac_q == '0)) begin
          spike_d  = 1'b1;
          refrac_d = RefW'(REFRAC_TICKS);
          if (!(&count_q)) begin
            count_d = count_q + CNT_W'(1);
          end
        end else if (refrac_q != '0) begin
          refrac_d = refrac_q - RefW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any update in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      k_q            <= '0;
      acc_q          <= '0;
      i_ext_q        <= '0;
      thresh_q       <= '0;
      alpha_q        <= '0;
      delta_q        <= '0;
      x_q            <= '0;
      voltage_q      <= '0;
      prev_q         <= '0;
      refrac_q       <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      spike_q        <= 1'b0;
      tick_dropped_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      acc_q          <= acc_d;
      i_ext_q        <= i_ext_d;
      thresh_q       <= thresh_d;
      alpha_q        <= alpha_d;
      delta_q        <= delta_d;
      x_q            <= x_d;
      voltage_q      <= voltage_d;
      prev_q         <= prev_d;
      refrac_q       <= refrac_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      spike_q        <= spike_d;
      tick_dropped_q <= tick_dropped_d;
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.out_valid    = out_valid_q;
  assign bus.spike        = spike_q;
  assign bus.voltage      = voltage_q;
  assign bus.x_state      = x_q;
  assign bus.spike_count  = count_q;
  assign bus.tick_dropped = tick_dropped_q;
endmodule
